// File: rtl/usbdev_pkg.sv
// Shared types for the USB device IN packet supplier: fetch FSM states and
// SRAM word/byte addressing constants.
package usbdev_pkg;

  typedef enum logic [1:0] {
    FetchIdle = 2'd0,
    FetchReq  = 2'd1,
    FetchWait = 2'd2
  } fetch_state_e;

  localparam int unsigned SramWordBytes = 4;
  localparam int unsigned ByteIdxW      = $clog2(SramWordBytes);

endpackage

// File: rtl/usbdev_in_pkt_supplier.sv
// Supplies IN packet bytes to the full-speed protocol engine: snapshots the
// endpoint config on each IN token and streams 32-bit words out of the packet SRAM.
module usbdev_in_pkt_supplier
  import usbdev_pkg::*;
#(
  parameter  int unsigned NumInEps       = 12,
  parameter  int unsigned MaxPktSizeByte = 64,
  parameter  int unsigned NumBufs        = 32,
  localparam int unsigned PktW           = $clog2(MaxPktSizeByte),
  localparam int unsigned BufW           = $clog2(NumBufs),
  localparam int unsigned SramAw         = BufW + PktW - 2
) (
  input  logic                         clk_48mhz_i,
  input  logic                         rst_i,
  input  logic                         link_reset_i,
  input  logic [NumInEps-1:0]          in_rdy_i,
  input  logic [NumInEps*BufW-1:0]     in_buf_i,
  input  logic [NumInEps*(PktW+1)-1:0] in_size_i,
  input  logic                         in_xact_starting_i,
  input  logic [3:0]                   in_xact_start_ep_i,
  input  logic [3:0]                   in_ep_current_i,
  input  logic [PktW-1:0]              in_ep_get_addr_i,
  input  logic                         in_ep_data_get_i,
  input  logic                         in_ep_rollback_i,
  input  logic                         in_ep_xact_end_i,
  output logic [NumInEps-1:0]          in_ep_has_data_o,
  output logic [NumInEps-1:0]          in_ep_data_done_o,
  output logic [7:0]                   in_ep_data_o,
  output logic                         mem_req_o,
  output logic [SramAw-1:0]            mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [31:0]                  mem_rdata_i,
  output logic [NumInEps-1:0]          in_rdy_clr_o,
  output logic [NumInEps-1:0]          in_sent_o
);

  localparam int unsigned WordW = PktW - ByteIdxW;

  fetch_state_e          state_q, state_d;
  logic [BufW-1:0]       buf_q, buf_d;
  logic [PktW:0]         size_q, size_d;
  logic [WordW-1:0]      word_q, word_d;
  logic [31:0]           word_data_q, word_data_d;
  logic                  valid_q, valid_d;
  logic                  discard_q, discard_d;
  logic                  pending_q, pending_d;
  logic                  cfg_vld_q, cfg_vld_d;
  logic [SramAw-1:0]     addr_q, addr_d;
  logic [NumInEps-1:0]   rdy_clr_q, rdy_clr_d;
  logic [NumInEps-1:0]   sent_q, sent_d;

  logic                  start_ep_ok, cur_ep_ok, in_pkt, start_nonzero;
  logic [BufW-1:0]       start_buf;
  logic [PktW:0]         start_size;
  logic [WordW-1:0]      get_word;
  logic [7:0]            sel_byte;
  logic                  unused_data_get;

  assign unused_data_get = in_ep_data_get_i;
  assign start_ep_ok     = 32'(in_xact_start_ep_i) < NumInEps;
  assign cur_ep_ok       = 32'(in_ep_current_i) < NumInEps;
  assign get_word        = in_ep_get_addr_i[PktW-1:ByteIdxW];
  assign in_pkt          = {1'b0, in_ep_get_addr_i} < size_q;
  assign start_nonzero   = start_size != '0;

  always_comb begin
    start_buf  = '0;
    start_size = '0;
    if (start_ep_ok) begin
      start_buf  = in_buf_i[32'(in_xact_start_ep_i)*BufW +: BufW];
      start_size = in_size_i[32'(in_xact_start_ep_i)*(PktW+1) +: (PktW+1)];
    end
  end

  always_comb begin
    case (in_ep_get_addr_i[1:0])
      2'd0:    sel_byte = word_data_q[7:0];
      2'd1:    sel_byte = word_data_q[15:8];
      2'd2:    sel_byte = word_data_q[23:16];
      default: sel_byte = word_data_q[31:24];
    endcase
    in_ep_data_o = valid_q ? sel_byte : 8'h00;
  end

  always_comb begin
    in_ep_data_done_o = '0;
    if (cfg_vld_q && cur_ep_ok && !in_pkt) in_ep_data_done_o[in_ep_current_i] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    size_d      = size_q;
    word_d      = word_q;
    word_data_d = word_data_q;
    valid_d     = valid_q;
    discard_d   = discard_q;
    pending_d   = pending_q;
    cfg_vld_d   = cfg_vld_q;
    addr_d      = addr_q;
    rdy_clr_d   = '0;
    sent_d      = '0;
    if (in_ep_xact_end_i && cur_ep_ok) begin
      rdy_clr_d[in_ep_current_i] = 1'b1;
      sent_d[in_ep_current_i]    = 1'b1;
    end

    case (state_q)
      FetchIdle: begin
        if (valid_q && in_pkt && get_word != word_q) begin
          word_d  = get_word;
          valid_d = 1'b0;
          addr_d  = {buf_q, get_word};
          state_d = FetchReq;
        end
      end
      FetchReq: begin
        if (mem_gnt_i) state_d = FetchWait;
      end
      FetchWait: begin
        if (mem_rvalid_i) begin
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            word_data_d = mem_rdata_i;
            valid_d     = 1'b1;
          end
          if (pending_q) begin
            pending_d = 1'b0;
            addr_d    = {buf_q, word_q};
            state_d   = FetchReq;
          end else begin
            state_d = FetchIdle;
          end
        end
      end
      default: state_d = FetchIdle;
    endcase

    if (in_ep_rollback_i) valid_d = 1'b0;

    // A new token never cancels a read the SRAM already owes us: the old
    // response is drained and dropped, then word 0 of the new buffer follows.
    if (in_xact_starting_i) begin
      buf_d     = start_buf;
      size_d    = start_size;
      word_d    = '0;
      valid_d   = 1'b0;
      cfg_vld_d = 1'b1;
      pending_d = 1'b0;
      if (state_q == FetchIdle || (state_q == FetchWait && mem_rvalid_i)) begin
        discard_d = 1'b0;
        addr_d    = {start_buf, {WordW{1'b0}}};
        state_d   = start_nonzero ? FetchReq : FetchIdle;
      end else begin
        discard_d = 1'b1;
        pending_d = start_nonzero;
      end
    end

    // A request granted in the reset cycle still produces a response, so it is drained too.
    if (link_reset_i) begin
      valid_d   = 1'b0;
      cfg_vld_d = 1'b0;
      pending_d = 1'b0;
      rdy_clr_d = '0;
      sent_d    = '0;
      case (state_q)
        FetchReq: begin
          state_d   = mem_gnt_i ? FetchWait : FetchIdle;
          discard_d = mem_gnt_i;
        end
        FetchWait: begin
          state_d   = mem_rvalid_i ? FetchIdle : FetchWait;
          discard_d = !mem_rvalid_i;
        end
        default: begin
          state_d   = FetchIdle;
          discard_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_48mhz_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FetchIdle;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
      pending_q <= 1'b0;
      cfg_vld_q <= 1'b0;
      addr_q    <= '0;
      rdy_clr_q <= '0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
      pending_q <= pending_d;
      cfg_vld_q <= cfg_vld_d;
      addr_q    <= addr_d;
      rdy_clr_q <= rdy_clr_d;
      sent_q    <= sent_d;
    end
  end

  always_ff @(posedge clk_48mhz_i) begin
    buf_q       <= buf_d;
    size_q      <= size_d;
    word_q      <= word_d;
    word_data_q <= word_data_d;
  end

  assign in_ep_has_data_o = in_rdy_i;
  assign mem_req_o        = (state_q == FetchReq);
  assign mem_addr_o       = addr_q;
  assign in_rdy_clr_o     = rdy_clr_q;
  assign in_sent_o        = sent_q;

endmodule

// File: tb/tb_usbdev_in_pkt_supplier.sv
// Directed bench for usbdev_in_pkt_supplier with an SRAM responder and a
// per-cycle model of has_data, data_done and the completion pulses.
module tb_usbdev_in_pkt_supplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        link_reset = 1'b0;
  logic [11:0] in_rdy = '0;
  logic [59:0] in_buf = '0;
  logic [83:0] in_size = '0;
  logic        starting = 1'b0;
  logic [3:0]  start_ep = '0;
  logic [3:0]  cur_ep = '0;
  logic [5:0]  get_addr = '0;
  logic        data_get = 1'b0;
  logic        rollback = 1'b0;
  logic        xact_end = 1'b0;

  logic [11:0] has_data, data_done, rdy_clr, sent;
  logic [7:0]  data;
  logic        mem_req, mem_gnt;
  logic [8:0]  mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        gnt_en = 1'b1;
  int          rlat = 1;
  int          lat_cnt = 0;
  logic [8:0]  raddr = '0;
  logic [31:0] sram [512];
  logic [8:0]  fetch_q [$];

  int          tests = 0;
  int          fails = 0;

  logic        m_active = 1'b0;
  logic [6:0]  m_size = '0;
  logic [11:0] m_pulse = '0;
  logic [11:0] done_exp;
  logic [7:0]  exp1 [6];

  usbdev_in_pkt_supplier dut (
    .clk_48mhz_i        (clk),
    .rst_i              (rst),
    .link_reset_i       (link_reset),
    .in_rdy_i           (in_rdy),
    .in_buf_i           (in_buf),
    .in_size_i          (in_size),
    .in_xact_starting_i (starting),
    .in_xact_start_ep_i (start_ep),
    .in_ep_current_i    (cur_ep),
    .in_ep_get_addr_i   (get_addr),
    .in_ep_data_get_i   (data_get),
    .in_ep_rollback_i   (rollback),
    .in_ep_xact_end_i   (xact_end),
    .in_ep_has_data_o   (has_data),
    .in_ep_data_done_o  (data_done),
    .in_ep_data_o       (data),
    .mem_req_o          (mem_req),
    .mem_addr_o         (mem_addr),
    .mem_gnt_i          (mem_gnt),
    .mem_rvalid_i       (mem_rvalid),
    .mem_rdata_i        (mem_rdata),
    .in_rdy_clr_o       (rdy_clr),
    .in_sent_o          (sent)
  );

  always #5 clk = ~clk;

  assign mem_gnt = mem_req & gnt_en;

  // SRAM: grant while enabled, answer rlat cycles after the grant cycle.
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (lat_cnt == 1) begin
      mem_rvalid <= 1'b1;
      mem_rdata  <= sram[raddr];
    end
    if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
    if (mem_req && mem_gnt) begin
      raddr <= mem_addr;
      fetch_q.push_back(mem_addr);
      if (rlat <= 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= sram[mem_addr];
        lat_cnt    <= 0;
      end else begin
        lat_cnt <= rlat - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: done is "offset past the snapshotted size" for the current ep;
  // completion pulses echo xact_end one cycle later.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      m_active = 1'b0;
      m_pulse  = '0;
    end else begin
      done_exp = '0;
      if (m_active && cur_ep < 12 && {1'b0, get_addr} >= m_size) done_exp[cur_ep] = 1'b1;
      chk("has_data", has_data, in_rdy);
      chk("data_done", data_done, done_exp);
      chk("rdy_clr", rdy_clr, m_pulse);
      chk("sent", sent, m_pulse);
      m_pulse = '0;
      if (xact_end && !link_reset && cur_ep < 12) m_pulse[cur_ep] = 1'b1;
      if (link_reset) begin
        m_active = 1'b0;
      end else if (starting) begin
        m_active = 1'b1;
        m_size   = (start_ep < 12) ? in_size[int'(start_ep)*7 +: 7] : 7'd0;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ep, input int b, input int sz);
    in_buf[ep*5 +: 5]  = b[4:0];
    in_size[ep*7 +: 7] = sz[6:0];
  endtask

  task automatic start_xact(input int ep);
    start_ep = ep[3:0];
    starting = 1'b1;
    cyc();
    starting = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded budget", $time);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    for (int i = 0; i < 512; i++) sram[i] = 32'hDEAD0000 | i;
    sram[9'h050] = 32'h44332211;
    sram[9'h051] = 32'h00006655;
    sram[9'h070] = 32'hDDCCBBAA;
    sram[9'h071] = 32'h12345678;
    for (int w = 0; w < 16; w++)
      for (int k = 0; k < 4; k++) sram[160 + w][k*8 +: 8] = 8'((4*w + k) ^ 8'hA5);
    exp1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset state
    in_rdy = 12'hA5C;
    cur_ep = 4'd2;
    repeat (3) cyc();
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 9'h000);
    chk("rst_data", data, 8'h00);
    chk("rst_done", data_done, 12'h000);
    chk("rst_clr", rdy_clr, 12'h000);
    chk("rst_sent", sent, 12'h000);
    chk("rst_has_data", has_data, 12'hA5C);
    rst = 1'b0;
    repeat (2) cyc();

    // ep 2, buf 5, size 6
    set_cfg(2, 5, 6);
    get_addr = '0;
    fetch_q.delete();
    start_xact(2);
    chk("t1_req", mem_req, 1'b1);
    chk("t1_addr0", mem_addr, 9'h050);
    repeat (3) cyc();
    chk("t1_byte0", data, 8'h11);
    for (int o = 1; o < 6; o++) begin
      get_addr = o[5:0];
      cyc();
      if (o == 4) begin
        chk("t1_refetch_req", mem_req, 1'b1);
        chk("t1_addr1", mem_addr, 9'h051);
      end
      repeat (5) cyc();
      chk("t1_byte", data, exp1[o]);
    end
    get_addr = 6'd6;
    cyc();
    chk("t1_done", data_done, 12'h004);
    chk("t1_nfetch", fetch_q.size(), 2);
    chk("t1_fetch0", fetch_q[0], 9'h050);
    chk("t1_fetch1", fetch_q[1], 9'h051);

    // Size 0, ep 1
    set_cfg(1, 3, 0);
    cur_ep = 4'd1;
    get_addr = '0;
    fetch_q.delete();
    start_xact(1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_noreq", mem_req, 1'b0);
      cyc();
    end
    chk("t2_done", data_done, 12'h002);
    chk("t2_nfetch", fetch_q.size(), 0);

    // Size 64 full read, ep 4, buf 10
    set_cfg(4, 10, 64);
    cur_ep = 4'd4;
    get_addr = '0;
    fetch_q.delete();
    start_xact(4);
    repeat (4) cyc();
    for (int o = 0; o < 64; o++) begin
      get_addr = o[5:0];
      repeat (6) cyc();
      chk("t3_byte", data, 8'(o ^ 8'hA5));
    end
    chk("t3_done_last", data_done, 12'h000);
    chk("t3_nfetch", fetch_q.size(), 16);
    for (int i = 0; i < 16; i++) chk("t3_fetch", fetch_q[i], 9'(160 + i));

    // Completion pulses vs rollback
    cur_ep = 4'd3;
    xact_end = 1'b1;
    cyc();
    xact_end = 1'b0;
    chk("t4_clr", rdy_clr, 12'h008);
    chk("t4_sent", sent, 12'h008);
    cyc();
    chk("t4_clr_off", rdy_clr, 12'h000);
    chk("t4_sent_off", sent, 12'h000);
    rollback = 1'b1;
    cyc();
    rollback = 1'b0;
    chk("t4_rb_clr", rdy_clr, 12'h000);
    chk("t4_rb_sent", sent, 12'h000);
    cyc();

    // New start while the old read is still in flight (3-cycle rvalid)
    set_cfg(5, 7, 8);
    rlat = 3;
    cur_ep = 4'd2;
    get_addr = '0;
    fetch_q.delete();
    start_xact(2);
    cyc();
    cur_ep = 4'd5;
    start_xact(5);
    cyc();
    cyc();
    chk("t5_discard", data, 8'h00);
    repeat (10) cyc();
    chk("t5_byte0", data, 8'hAA);
    get_addr = 6'd1;
    cyc();
    chk("t5_byte1", data, 8'hBB);
    chk("t5_nfetch", fetch_q.size(), 2);
    chk("t5_fetch0", fetch_q[0], 9'h050);
    chk("t5_fetch1", fetch_q[1], 9'h070);

    // Grant stall, then link reset while waiting for rvalid
    rlat = 4;
    gnt_en = 1'b0;
    cur_ep = 4'd2;
    get_addr = '0;
    fetch_q.delete();
    start_xact(2);
    for (int i = 0; i < 5; i++) begin
      chk("t6_req_hold", mem_req, 1'b1);
      chk("t6_addr_hold", mem_addr, 9'h050);
      cyc();
    end
    gnt_en = 1'b1;
    cyc();
    link_reset = 1'b1;
    cyc();
    link_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t6_lr_req", mem_req, 1'b0);
      chk("t6_lr_data", data, 8'h00);
      chk("t6_lr_done", data_done, 12'h000);
      cyc();
    end
    chk("t6_nfetch", fetch_q.size(), 1);
    rlat = 1;
    start_xact(2);
    repeat (4) cyc();
    chk("t6_restart_byte", data, 8'h11);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
